riscv_v_exe_seq: RTL and testbench

Micro-op sequencer for the vector execute ALU. Accepts one decoded vector instruction at a time, cracks it into per-register micro-ops according to LMUL, drives register-file reads, and generates ALU-valid and writeback strobes. Paces multiply micro-ops so they wait out the non-pipelined multiplier latency. Sits between vector decode and the execute ALU / writeback stage.

---
 rtl/riscv_v_pkg.sv | 21 ++
 rtl/riscv_v_exe_seq_addr_gen.sv | 38 +++
 rtl/riscv_v_exe_seq.sv | 194 +++++++++++++++++++
 tb/tb_riscv_v_exe_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_v_pkg.sv
// Shared types and constants for the vector execute micro-op sequencer.
//   riscv_v_exe_seq_state_e : sequencer FSM states
//   riscv_v_lmul_t          : log2(LMUL) field as presented by decode
//   riscv_v_vreg_addr_t     : vector register address for the default register count
//   RISCV_V_EXE_MUL_LAT     : default multiplier latency (issue to result, cycles)
package riscv_v_pkg;

  localparam int unsigned RISCV_V_EXE_MUL_LAT = 3;
  localparam int unsigned RISCV_V_NUM_VREGS   = 32;

  typedef logic [$clog2(RISCV_V_NUM_VREGS)-1:0] riscv_v_vreg_addr_t;
  typedef logic [1:0] riscv_v_lmul_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StMulWait,
    StDrain
  } riscv_v_exe_seq_state_e;

endpackage

// File: rtl/riscv_v_exe_seq_addr_gen.sv
// Register address generation for the vector execute sequencer.
// Adds the micro-op index to each base register, wrapping modulo NUM_VREGS.
//   i_vs1 / i_vs2 / i_vd : base registers of the instruction
//   i_cnt                : micro-op index used for the source reads
//   i_wb_cnt             : micro-op index used for the writeback register
//   o_addra / o_addrb    : source read addresses
//   o_wb_addr            : writeback address
module riscv_v_exe_seq_addr_gen #(
  parameter int unsigned NUM_VREGS = 32,
  localparam int unsigned VA = $clog2(NUM_VREGS)
) (
  input  logic [VA-1:0] i_vs1,
  input  logic [VA-1:0] i_vs2,
  input  logic [VA-1:0] i_vd,
  input  logic [2:0]    i_cnt,
  input  logic [2:0]    i_wb_cnt,
  output logic [VA-1:0] o_addra,
  output logic [VA-1:0] o_addrb,
  output logic [VA-1:0] o_wb_addr
);

  localparam int unsigned SW = VA + 1;

  // One conditional subtract is enough: the offset never exceeds 7 < NUM_VREGS.
  function automatic logic [VA-1:0] wrap_add(input logic [VA-1:0] base, input logic [2:0] off);
    logic [SW-1:0] sum;
    sum = {1'b0, base} + SW'(off);
    if (sum >= SW'(NUM_VREGS)) begin
      sum = sum - SW'(NUM_VREGS);
    end
    return sum[VA-1:0];
  endfunction

  assign o_addra   = wrap_add(i_vs1, i_cnt);
  assign o_addrb   = wrap_add(i_vs2, i_cnt);
  assign o_wb_addr = wrap_add(i_vd, i_wb_cnt);

endmodule

// File: rtl/riscv_v_exe_seq.sv
// Vector execute micro-op sequencer. Cracks one decoded instruction into per-register
// micro-ops, drives register-file reads, ALU-valid and writeback strobes, and paces
// multiply micro-ops around the non-pipelined multiplier.
// Optional feature macro RISCV_V_EXE_SEQ_LMUL_EN: when defined req_lmul is honoured
// (1..8 micro-ops); when undefined every instruction is a single micro-op.
// Ports:
//   i_clk, i_rst (sync, active high), i_kill (abort in-flight instruction)
//   i_req_valid / o_req_ready, i_req_vd/vs1/vs2, i_req_lmul, i_req_is_mul, i_req_is_reduct
//   o_rf_rd_en, o_rf_rd_addra, o_rf_rd_addrb : register-file read port
//   o_alu_valid, o_alu_first                 : operand-valid strobe, first micro-op flag
//   o_wb_valid, o_wb_addr, o_wb_last         : writeback strobe, address, final flag
//   o_busy                                   : an instruction is in flight
module riscv_v_exe_seq
  import riscv_v_pkg::*;
#(
  parameter int unsigned MUL_LAT   = RISCV_V_EXE_MUL_LAT,
  parameter int unsigned NUM_VREGS = 32,
  localparam int unsigned VA = $clog2(NUM_VREGS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_kill,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [VA-1:0] i_req_vd,
  input  logic [VA-1:0] i_req_vs1,
  input  logic [VA-1:0] i_req_vs2,
  input  riscv_v_lmul_t i_req_lmul,
  input  logic          i_req_is_mul,
  input  logic          i_req_is_reduct,
  output logic          o_rf_rd_en,
  output logic [VA-1:0] o_rf_rd_addra,
  output logic [VA-1:0] o_rf_rd_addrb,
  output logic          o_alu_valid,
  output logic          o_alu_first,
  output logic          o_wb_valid,
  output logic [VA-1:0] o_wb_addr,
  output logic          o_wb_last,
  output logic          o_busy
);

  localparam logic [2:0] WaitInit = 3'(MUL_LAT - 1);

  riscv_v_exe_seq_state_e r_state, w_state_d;
  logic [VA-1:0] r_vd, r_vs1, r_vs2;
  logic          r_is_mul, r_is_reduct;
  logic [2:0]    r_wcnt, w_wcnt_d;
  logic [2:0]    w_cnt;
  logic          w_last;
  logic          w_flush, w_accept, w_cnt_inc, w_issue, w_mul_wb_cyc, w_wb_valid;
  logic          r_alu_valid, r_alu_first, r_wb_valid, r_wb_last;
  logic [VA-1:0] r_wb_addr;
  logic [VA-1:0] w_addra, w_addrb, w_wb_addr;

  assign w_flush      = i_rst | i_kill;
  assign w_issue      = (r_state == StIssue);
  assign w_mul_wb_cyc = (r_state == StMulWait) && (r_wcnt == 3'd0);

`ifdef RISCV_V_EXE_SEQ_LMUL_EN
  logic [2:0] r_cnt, r_n_m1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_n_m1 <= '0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_n_m1 <= 3'((4'd1 << i_req_lmul) - 4'd1);
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  assign w_cnt  = r_cnt;
  assign w_last = (r_cnt == r_n_m1);
`else
  logic w_unused_lmul;
  assign w_unused_lmul = ^{i_req_lmul, w_cnt_inc};
  assign w_cnt         = '0;
  assign w_last        = 1'b1;
`endif

  always_comb begin
    w_state_d = r_state;
    w_wcnt_d  = r_wcnt;
    w_accept  = 1'b0;
    w_cnt_inc = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          w_accept  = 1'b1;
          w_state_d = StIssue;
        end
      end
      StIssue: begin
        if (r_is_mul) begin
          w_wcnt_d  = WaitInit;
          w_state_d = StMulWait;
        end else if (w_last) begin
          w_state_d = StDrain;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      StMulWait: begin
        if (r_wcnt == 3'd0) begin
          if (w_last) begin
            w_state_d = StIdle;
          end else begin
            w_cnt_inc = 1'b1;
            w_state_d = StIssue;
          end
        end else begin
          w_wcnt_d = r_wcnt - 3'd1;
        end
      end
      StDrain: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    // Abort wins over every transition, including acceptance of a new request.
    if (w_flush) begin
      w_state_d = StIdle;
      w_accept  = 1'b0;
      w_cnt_inc = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_wcnt      <= '0;
      r_vd        <= '0;
      r_vs1       <= '0;
      r_vs2       <= '0;
      r_is_mul    <= 1'b0;
      r_is_reduct <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_wcnt  <= w_wcnt_d;
      if (w_accept) begin
        r_vd        <= i_req_vd;
        r_vs1       <= i_req_vs1;
        r_vs2       <= i_req_vs2;
        r_is_mul    <= i_req_is_mul;
        r_is_reduct <= i_req_is_reduct;
      end
    end
  end

  riscv_v_exe_seq_addr_gen #(
    .NUM_VREGS (NUM_VREGS)
  ) u_addr_gen (
    .i_vs1     (r_vs1),
    .i_vs2     (r_vs2),
    .i_vd      (r_vd),
    .i_cnt     (w_cnt),
    .i_wb_cnt  (r_is_reduct ? 3'd0 : w_cnt),
    .o_addra   (w_addra),
    .o_addrb   (w_addrb),
    .o_wb_addr (w_wb_addr)
  );

  // Non-mul micro-ops retire the cycle after issue; mul writeback is decoded from the
  // wait counter instead.
  always_ff @(posedge i_clk) begin
    if (w_flush) begin
      r_alu_valid <= 1'b0;
      r_alu_first <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_last   <= 1'b0;
      r_wb_addr   <= '0;
    end else begin
      r_alu_valid <= w_issue;
      r_alu_first <= w_issue & (w_cnt == 3'd0);
      r_wb_valid  <= w_issue & ~r_is_mul & (~r_is_reduct | w_last);
      r_wb_last   <= w_issue & ~r_is_mul & w_last;
      r_wb_addr   <= w_wb_addr;
    end
  end

  assign w_wb_valid = ~w_flush & (r_wb_valid | (w_mul_wb_cyc & (~r_is_reduct | w_last)));

  assign o_req_ready   = (r_state == StIdle) & ~w_flush;
  assign o_rf_rd_en    = w_issue & ~w_flush;
  assign o_rf_rd_addra = o_rf_rd_en ? w_addra : '0;
  assign o_rf_rd_addrb = o_rf_rd_en ? w_addrb : '0;
  assign o_alu_valid   = r_alu_valid & ~w_flush;
  assign o_alu_first   = r_alu_first & ~w_flush;
  assign o_wb_valid    = w_wb_valid;
  assign o_wb_addr     = w_wb_valid ? (w_mul_wb_cyc ? w_wb_addr : r_wb_addr) : '0;
  assign o_wb_last     = w_wb_valid & (r_wb_last | (w_mul_wb_cyc & w_last));
  assign o_busy        = (r_state != StIdle) & ~i_rst;

endmodule

// File: tb/tb_riscv_v_exe_seq.sv
// Directed bench for riscv_v_exe_seq (MUL_LAT=3, 32 registers). Each cycle the full
// output vector is compared against a hand-computed value. Expectations follow the
// build: RISCV_V_EXE_SEQ_LMUL_EN selects the multi-micro-op vectors.
module tb_riscv_v_exe_seq;

  localparam int unsigned MulLat = 3;

  logic       clk = 1'b0;
  logic       rst, kill, req_valid, req_ready;
  logic [4:0] req_vd, req_vs1, req_vs2;
  logic [1:0] req_lmul;
  logic       req_is_mul, req_is_reduct;
  logic       rd_en, alu_valid, alu_first, wb_valid, wb_last, busy;
  logic [4:0] addra, addrb, wb_addr;
  logic [21:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  riscv_v_exe_seq #(
    .MUL_LAT   (MulLat),
    .NUM_VREGS (32)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_kill          (kill),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_vd        (req_vd),
    .i_req_vs1       (req_vs1),
    .i_req_vs2       (req_vs2),
    .i_req_lmul      (req_lmul),
    .i_req_is_mul    (req_is_mul),
    .i_req_is_reduct (req_is_reduct),
    .o_rf_rd_en      (rd_en),
    .o_rf_rd_addra   (addra),
    .o_rf_rd_addrb   (addrb),
    .o_alu_valid     (alu_valid),
    .o_alu_first     (alu_first),
    .o_wb_valid      (wb_valid),
    .o_wb_addr       (wb_addr),
    .o_wb_last       (wb_last),
    .o_busy          (busy)
  );

  assign obs = {rd_en, addra, addrb, alu_valid, alu_first, wb_valid, wb_addr, wb_last,
                req_ready, busy};

  function automatic logic [21:0] pk(input logic rd, input logic [4:0] a, input logic [4:0] b,
                                     input logic av, input logic af, input logic wv,
                                     input logic [4:0] wa, input logic wl, input logic rdy,
                                     input logic bsy);
    return {rd, a, b, av, af, wv, wa, wl, rdy, bsy};
  endfunction

  localparam logic [21:0] Idle = 22'h2;  // only req_ready
  localparam logic [21:0] Busy = 22'h1;  // only busy

  // Compare outputs mid-cycle, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [21:0] exp);
    @(negedge clk);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  // Present a request, check the accept cycle, optionally keep req_valid asserted.
  task automatic send(input string tag, input logic [4:0] vd, input logic [4:0] vs1,
                      input logic [4:0] vs2, input logic [1:0] lmul, input logic mul,
                      input logic red, input logic hold);
    req_vd        = vd;
    req_vs1       = vs1;
    req_vs2       = vs2;
    req_lmul      = lmul;
    req_is_mul    = mul;
    req_is_reduct = red;
    req_valid     = 1'b1;
    cyc(tag, Idle);
    if (!hold) req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; kill = 1'b0; req_valid = 1'b0;
    req_vd = '0; req_vs1 = '0; req_vs2 = '0; req_lmul = '0;
    req_is_mul = 1'b0; req_is_reduct = 1'b0;
    @(posedge clk);
    #1;
    cyc("rst_cycle", 22'h0);
    rst = 1'b0;
    cyc("post_rst", Idle);

`ifdef RISCV_V_EXE_SEQ_LMUL_EN
    // Add, N=4: reads 4/8..7/11, writes 12..15.
    send("add_c0", 5'd12, 5'd4, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc("add_c1", pk(1, 4, 8, 0, 0, 0, 0, 0, 0, 1));
    cyc("add_c2", pk(1, 5, 9, 1, 1, 1, 12, 0, 0, 1));
    cyc("add_c3", pk(1, 6, 10, 1, 0, 1, 13, 0, 0, 1));
    cyc("add_c4", pk(1, 7, 11, 1, 0, 1, 14, 0, 0, 1));
    cyc("add_c5", pk(0, 0, 0, 1, 0, 1, 15, 1, 0, 1));
    cyc("add_c6", Idle);

    // Mul, N=2: issue at 1 and 5, writeback at 4 and 8.
    send("mul_c0", 5'd3, 5'd1, 5'd2, 2'd1, 1'b1, 1'b0, 1'b0);
    cyc("mul_c1", pk(1, 1, 2, 0, 0, 0, 0, 0, 0, 1));
    cyc("mul_c2", pk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    cyc("mul_c3", Busy);
    cyc("mul_c4", pk(0, 0, 0, 0, 0, 1, 3, 0, 0, 1));
    cyc("mul_c5", pk(1, 2, 3, 0, 0, 0, 0, 0, 0, 1));
    cyc("mul_c6", pk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    cyc("mul_c7", Busy);
    cyc("mul_c8", pk(0, 0, 0, 0, 0, 1, 4, 1, 0, 1));
    cyc("mul_c9", Idle);

    // Reduction, N=8, vd=0: single writeback at cycle 9.
    send("red_c0", 5'd0, 5'd16, 5'd24, 2'd3, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cyc($sformatf("red_c%0d", k + 1),
          pk(1, 5'(16 + k), 5'(24 + k), k > 0, k == 1, 0, 0, 0, 0, 1));
    end
    cyc("red_c9", pk(0, 0, 0, 1, 0, 1, 0, 1, 0, 1));
    cyc("red_c10", Idle);

    // Wrap: vs1=30 -> 30,31,0,1; vd=31 -> 31,0,1,2.
    send("wrap_c0", 5'd31, 5'd30, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc($sformatf("wrap_c%0d", k + 1),
          pk(1, 5'((30 + k) % 32), 5'(k), k > 0, k == 1, k > 0,
             (k > 0) ? 5'((30 + k) % 32) : 5'd0, 0, 0, 1));
    end
    cyc("wrap_c5", pk(0, 0, 0, 1, 0, 1, 2, 1, 0, 1));
    cyc("wrap_c6", Idle);

    // Kill in cycle 3 of an N=8 add.
    send("kill_c0", 5'd16, 5'd0, 5'd8, 2'd3, 1'b0, 1'b0, 1'b0);
    cyc("kill_c1", pk(1, 0, 8, 0, 0, 0, 0, 0, 0, 1));
    cyc("kill_c2", pk(1, 1, 9, 1, 1, 1, 16, 0, 0, 1));
    kill = 1'b1;
    cyc("kill_c3", Busy);
    kill = 1'b0;
    cyc("kill_c4", Idle);
    cyc("kill_c5", Idle);

    // Reset during MUL_WAIT.
    send("rstmw_c0", 5'd5, 5'd6, 5'd7, 2'd1, 1'b1, 1'b0, 1'b0);
    cyc("rstmw_c1", pk(1, 6, 7, 0, 0, 0, 0, 0, 0, 1));
    cyc("rstmw_c2", pk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    rst = 1'b1;
    cyc("rstmw_c3", 22'h0);
    rst = 1'b0;
    cyc("rstmw_c4", Idle);
    cyc("rstmw_c5", Idle);

    // req_valid held while busy: second accept only once idle again.
    send("hold_c0", 5'd4, 5'd2, 5'd3, 2'd1, 1'b0, 1'b0, 1'b1);
    cyc("hold_c1", pk(1, 2, 3, 0, 0, 0, 0, 0, 0, 1));
    cyc("hold_c2", pk(1, 3, 4, 1, 1, 1, 4, 0, 0, 1));
    cyc("hold_c3", pk(0, 0, 0, 1, 0, 1, 5, 1, 0, 1));
    cyc("hold_c4", Idle);
    req_valid = 1'b0;
    cyc("hold_c5", pk(1, 2, 3, 0, 0, 0, 0, 0, 0, 1));
`else
    // Add with lmul=3 ignored: exactly one micro-op.
    send("add_c0", 5'd12, 5'd4, 5'd8, 2'd3, 1'b0, 1'b0, 1'b0);
    cyc("add_c1", pk(1, 4, 8, 0, 0, 0, 0, 0, 0, 1));
    cyc("add_c2", pk(0, 0, 0, 1, 1, 1, 12, 1, 0, 1));
    cyc("add_c3", Idle);

    // Mul: issue at 1, writeback at 1+MUL_LAT.
    send("mul_c0", 5'd29, 5'd30, 5'd31, 2'd1, 1'b1, 1'b0, 1'b0);
    cyc("mul_c1", pk(1, 30, 31, 0, 0, 0, 0, 0, 0, 1));
    cyc("mul_c2", pk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    cyc("mul_c3", Busy);
    cyc("mul_c4", pk(0, 0, 0, 0, 0, 1, 29, 1, 0, 1));
    cyc("mul_c5", Idle);

    // Reduction: single writeback to vd.
    send("red_c0", 5'd7, 5'd1, 5'd2, 2'd2, 1'b0, 1'b1, 1'b0);
    cyc("red_c1", pk(1, 1, 2, 0, 0, 0, 0, 0, 0, 1));
    cyc("red_c2", pk(0, 0, 0, 1, 1, 1, 7, 1, 0, 1));
    cyc("red_c3", Idle);

    // Kill during MUL_WAIT suppresses alu_valid and the later writeback.
    send("kill_c0", 5'd5, 5'd6, 5'd7, 2'd0, 1'b1, 1'b0, 1'b0);
    cyc("kill_c1", pk(1, 6, 7, 0, 0, 0, 0, 0, 0, 1));
    kill = 1'b1;
    cyc("kill_c2", Busy);
    kill = 1'b0;
    cyc("kill_c3", Idle);
    cyc("kill_c4", Idle);

    // Reset during MUL_WAIT.
    send("rstmw_c0", 5'd9, 5'd10, 5'd11, 2'd0, 1'b1, 1'b0, 1'b0);
    cyc("rstmw_c1", pk(1, 10, 11, 0, 0, 0, 0, 0, 0, 1));
    cyc("rstmw_c2", pk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    rst = 1'b1;
    cyc("rstmw_c3", 22'h0);
    rst = 1'b0;
    cyc("rstmw_c4", Idle);
    cyc("rstmw_c5", Idle);

    // req_valid held while busy: second accept only once idle again.
    send("hold_c0", 5'd3, 5'd1, 5'd2, 2'd0, 1'b0, 1'b0, 1'b1);
    cyc("hold_c1", pk(1, 1, 2, 0, 0, 0, 0, 0, 0, 1));
    cyc("hold_c2", pk(0, 0, 0, 1, 1, 1, 3, 1, 0, 1));
    cyc("hold_c3", Idle);
    cyc("hold_c4", pk(1, 1, 2, 0, 0, 0, 0, 0, 0, 1));
    req_valid = 1'b0;
    cyc("hold_c5", pk(0, 0, 0, 1, 1, 1, 3, 1, 0, 1));
    cyc("hold_c6", Idle);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
